vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 The block SHALL have parameter H_SYNC_END, default 96; hSync is low for hCount 0..H_SYNC_END-1.
REQ-003 The block SHALL have parameter H_ACT_START, default 144, first visible hCount.
REQ-004 The block SHALL have parameter H_ACT_END, default 784, first non-visible hCount after the active region.
REQ-005 The block SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-006 The block SHALL have parameter V_SYNC_END, default 2; vSync is low for vCount 0..V_SYNC_END-1.
REQ-007 The block SHALL have parameter V_ACT_START, default 35, first visible vCount.
REQ-008 The block SHALL have parameter V_ACT_END, default 515, first non-visible vCount after the active region.
REQ-009 The block SHALL have parameter CLK_DIV, default 4, system clocks per pixel (power of two, 2..16).
REQ-010 The block SHALL have port clk, input, 1, system clock (100 MHz); one clock only, all logic on its rising edge.
REQ-011 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-012 The block SHALL have port pix_en, output, 1, high for one clk in every CLK_DIV clks.
REQ-013 The block SHALL have port hCount, output, 10, horizontal pixel counter.
REQ-014 The block SHALL have port vCount, output, 10, vertical line counter.
REQ-015 The block SHALL have port hSync, output, 1, active-low horizontal sync.
REQ-016 The block SHALL have port vSync, output, 1, active-low vertical sync.
REQ-017 The block SHALL have port bright, output, 1, high when (hCount,vCount) is in the visible region.
REQ-018 The block SHALL have port frame_tick, output, 1, one-clk pulse at frame start.
REQ-019 The block SHALL have port frame_count, output, 16, frames completed since reset.

Function
REQ-020 The divider SHALL be a log2(CLK_DIV)-bit counter that increments every clk and wraps; pix_en SHALL be asserted exactly when it equals CLK_DIV-1.
REQ-021 hCount SHALL change only on a clk edge where pix_en is high: increment if below H_TOTAL-1, otherwise go to 0.
REQ-022 vCount SHALL change only on an edge where pix_en is high and hCount equals H_TOTAL-1: increment if below V_TOTAL-1, otherwise go to 0.
REQ-023 hSync SHALL be 0 iff hCount < H_SYNC_END; vSync SHALL be 0 iff vCount < V_SYNC_END; both SHALL be decoded from the registered counters with zero added latency.
REQ-024 bright SHALL be 1 iff H_ACT_START <= hCount < H_ACT_END and V_ACT_START <= vCount < V_ACT_END.
REQ-025 On the edge where (hCount,vCount) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0), frame_tick SHALL be registered high for exactly the following clk cycle and frame_count SHALL increment by 1, wrapping modulo 2^16.
REQ-026 frame_tick SHALL NOT be asserted for any other counter transition; there SHALL be exactly one pulse per frame.
REQ-027 Counters SHALL never hold values >= their TOTAL; the downstream pixel generator relies on this bound.

Reset
REQ-028 While reset is 0, the divider, hCount, vCount, frame_count SHALL be 0 and frame_tick SHALL be 0, independent of clk.
REQ-029 Consequently, during reset hSync=0, vSync=0, bright=0, pix_en=0.
REQ-030 Assertion of reset mid-frame SHALL clear all state immediately; after release, timing SHALL restart from (0,0) with the first pix_en on the CLK_DIV-th rising clk edge.

Verification
REQ-031 Reset release, defaults -> pix_en high in 4th cycle and every 4th after; hCount reaches 1 after the 4th edge, 799 then 0 after 3200 clks.
REQ-032 Run one line -> hSync low for exactly 96 pixels (384 clks), high for 704; vCount increments exactly once per 800 pixels.
REQ-033 Run full frame -> vSync low for lines 0..1 only; bright high for exactly 640x480=307200 pixel periods; first bright at (144,35), last at (783,514).
REQ-034 Run 3 frames -> frame_tick pulses exactly 3 times, each 1 clk wide, 420000 pixels (1680000 clks) apart; frame_count = 3.
REQ-035 Assert reset at (hCount,vCount)=(400,300) without clk edge -> all outputs go to reset values asynchronously; after release timing restarts from (0,0).
REQ-036 Preload frame_count to 65535 (force) and complete a frame -> frame_count = 0, frame_tick still pulses once.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock-enable divider produces one pixel strobe every CLK_DIV system
// clocks; horizontal and vertical counters advance on that strobe and the
// sync / visible-region flags are decoded combinationally from the counter
// registers, so they line up with hCount/vCount with no extra latency.
//
// Strobe semantics: pix_en is a single-cycle enable, never a handshake.
// Consumers sample hCount/vCount/bright/syncs on any clk edge; the values
// only move on the edge where pix_en is high.
module vga_timing_gen #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC_END  = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC_END  = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int CLK_DIV     = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_B = 10'(H_SYNC_END);
  localparam logic [9:0] V_SYNC_B = 10'(V_SYNC_END);
  localparam logic [9:0] H_ACT_S  = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_E  = 10'(H_ACT_END);
  localparam logic [9:0] V_ACT_S  = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_E  = 10'(V_ACT_END);

  logic [DIV_W-1:0] div_cnt;
  logic             line_end;
  logic             frame_end;

  // Pixel strobe: the divider sits at 0 in reset, so pix_en is low there and
  // the first strobe arrives on the CLK_DIV-th edge after release.
  assign pix_en    = (div_cnt == DIV_LAST);
  assign line_end  = pix_en && (hCount == H_LAST);
  assign frame_end = line_end && (vCount == V_LAST);

  // Free-running divider; power-of-two CLK_DIV lets it wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Horizontal counter: steps once per pixel, wraps at H_TOTAL-1 so it can
  // never exceed the line length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hCount <= '0;
    end else if (pix_en) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  // Vertical counter: steps only on the last pixel of a line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vCount <= '0;
    end else if (line_end) begin
      if (vCount == V_LAST) begin
        vCount <= '0;
      end else begin
        vCount <= vCount + 10'd1;
      end
    end
  end

  // Frame bookkeeping: a registered one-clk pulse after the (last,last) ->
  // (0,0) wrap, and a 16-bit frame counter that wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Sync and visible-region decode straight from the counter registers.
  always_comb begin
    hSync  = (hCount >= H_SYNC_B);
    vSync  = (vCount >= V_SYNC_B);
    bright = (hCount >= H_ACT_S) && (hCount < H_ACT_E) &&
             (vCount >= V_ACT_S) && (vCount < V_ACT_E);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// Two instances share clk/reset: one with default 640x480 timing (checked over
// one full line), one with a tiny 20x10 raster so whole frames stay short.
// Small raster: H_TOTAL=20 H_SYNC_END=3 H_ACT=5..16, V_TOTAL=10 V_SYNC_END=2
// V_ACT=3..7, CLK_DIV=4 -> 200 pixels / 800 clks per frame, 60 visible pixels.
module tb_vga_timing_gen;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-parameter DUT ----------------
  logic        d_pix_en, d_hSync, d_vSync, d_bright, d_frame_tick;
  logic [9:0]  d_hCount, d_vCount;
  logic [15:0] d_frame_count;

  vga_timing_gen dut_d (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (d_pix_en),
    .hCount      (d_hCount),
    .vCount      (d_vCount),
    .hSync       (d_hSync),
    .vSync       (d_vSync),
    .bright      (d_bright),
    .frame_tick  (d_frame_tick),
    .frame_count (d_frame_count)
  );

  // ---------------- small-raster DUT ----------------
  logic        s_pix_en, s_hSync, s_vSync, s_bright, s_frame_tick;
  logic [9:0]  s_hCount, s_vCount;
  logic [15:0] s_frame_count;

  vga_timing_gen #(
    .H_TOTAL     (20),
    .H_SYNC_END  (3),
    .H_ACT_START (5),
    .H_ACT_END   (17),
    .V_TOTAL     (10),
    .V_SYNC_END  (2),
    .V_ACT_START (3),
    .V_ACT_END   (8),
    .CLK_DIV     (4)
  ) dut_s (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (s_pix_en),
    .hCount      (s_hCount),
    .vCount      (s_vCount),
    .hSync       (s_hSync),
    .vSync       (s_vSync),
    .bright      (s_bright),
    .frame_tick  (s_frame_tick),
    .frame_count (s_frame_count)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clk periods; returns on a falling edge, away from the active edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int pat_bad, pix_cnt, hs_low, v_chg;
    int bright_clks, tick_clks, pulses, last_pulse, spacing_bad, first_pulse;
    int vs_low, hs_low_s;
    logic [9:0] prev_v, max_h, max_v;
    logic [19:0] first_pos, last_pos;
    logic first_seen, prev_tick;

    // ---- reset state, both instances ----
    reset = 1'b0;
    step(3);
    check("d_rst_flags", {27'd0, d_pix_en, d_hSync, d_vSync, d_bright, d_frame_tick}, 32'd0);
    check("d_rst_cnt", {12'd0, d_hCount, d_vCount}, 32'd0);
    check("d_rst_fc", {16'd0, d_frame_count}, 32'd0);

    // ---- default timing over one full line (3200 clks) ----
    reset = 1'b1;
    pat_bad = 0; pix_cnt = 0; hs_low = 0; v_chg = 0;
    prev_v = d_vCount;
    for (int c = 1; c <= 3200; c++) begin
      @(negedge clk);
      if (c == 2) check("d_pix_en_c2", {31'd0, d_pix_en}, 32'd0);
      if (c == 3) begin
        check("d_pix_en_c3", {31'd0, d_pix_en}, 32'd1);
        check("d_h_c3", {22'd0, d_hCount}, 32'd0);
      end
      if (c == 4) check("d_h_c4", {22'd0, d_hCount}, 32'd1);
      if (c == 3196) check("d_h_799", {22'd0, d_hCount}, 32'd799);
      if (c == 3200) begin
        check("d_h_wrap", {22'd0, d_hCount}, 32'd0);
        check("d_v_after_line", {22'd0, d_vCount}, 32'd1);
      end
      if (d_pix_en !== ((c % 4) == 3)) pat_bad++;
      if (d_pix_en) pix_cnt++;
      if (!d_hSync) hs_low++;
      if (d_vCount != prev_v) v_chg++;
      prev_v = d_vCount;
    end
    check("d_pix_pattern_bad", pat_bad, 32'd0);
    check("d_pix_count", pix_cnt, 32'd800);
    check("d_hsync_low_clks", hs_low, 32'd384);
    check("d_v_changes", v_chg, 32'd1);

    // ---- small raster: three full frames ----
    reset = 1'b0;
    step(2);
    check("s_rst_cnt", {12'd0, s_hCount, s_vCount}, 32'd0);
    check("s_rst_flags", {27'd0, s_pix_en, s_hSync, s_vSync, s_bright, s_frame_tick}, 32'd0);
    reset = 1'b1;
    bright_clks = 0; tick_clks = 0; pulses = 0; last_pulse = 0; spacing_bad = 0;
    first_pulse = 0; vs_low = 0; hs_low_s = 0;
    max_h = '0; max_v = '0; first_pos = '0; last_pos = '0;
    first_seen = 1'b0; prev_tick = 1'b0;
    for (int c = 1; c <= 2400; c++) begin
      @(negedge clk);
      if (c == 799) begin
        check("s_fc_before_wrap", {16'd0, s_frame_count}, 32'd0);
        check("s_tick_before_wrap", {31'd0, s_frame_tick}, 32'd0);
      end
      if (c == 800) begin
        check("s_fc_after_wrap", {16'd0, s_frame_count}, 32'd1);
        check("s_tick_after_wrap", {31'd0, s_frame_tick}, 32'd1);
      end
      if (s_bright) begin
        bright_clks++;
        if (!first_seen) begin
          first_pos = {s_hCount, s_vCount};
          first_seen = 1'b1;
        end
        if (c <= 800) last_pos = {s_hCount, s_vCount};
      end
      if (s_frame_tick) begin
        tick_clks++;
        if (!prev_tick) begin
          pulses++;
          if (last_pulse != 0 && (c - last_pulse) != 800) spacing_bad++;
          if (last_pulse == 0) first_pulse = c;
          last_pulse = c;
        end
      end
      prev_tick = s_frame_tick;
      if (!s_vSync) vs_low++;
      if (!s_hSync) hs_low_s++;
      if (s_hCount > max_h) max_h = s_hCount;
      if (s_vCount > max_v) max_v = s_vCount;
    end
    check("s_bright_clks", bright_clks, 32'd720);
    check("s_first_bright", {12'd0, first_pos}, {12'd0, 10'd5, 10'd3});
    check("s_last_bright", {12'd0, last_pos}, {12'd0, 10'd16, 10'd7});
    check("s_pulses", pulses, 32'd3);
    check("s_tick_clks", tick_clks, 32'd3);
    check("s_first_pulse_clk", first_pulse, 32'd800);
    check("s_pulse_spacing_bad", spacing_bad, 32'd0);
    check("s_frame_count_3", {16'd0, s_frame_count}, 32'd3);
    check("s_vsync_low_clks", vs_low, 32'd480);
    check("s_hsync_low_clks", hs_low_s, 32'd360);
    check("s_max_h", {22'd0, max_h}, 32'd19);
    check("s_max_v", {22'd0, max_v}, 32'd9);

    // ---- mid-frame asynchronous reset at (10,5) ----
    step(440);
    check("s_mid_pos", {12'd0, s_hCount, s_vCount}, {12'd0, 10'd10, 10'd5});
    check("s_mid_flags", {28'd0, s_hSync, s_vSync, s_bright, s_frame_tick}, 32'b1110);
    #2 reset = 1'b0;
    #1;
    check("s_async_cnt", {12'd0, s_hCount, s_vCount}, 32'd0);
    check("s_async_fc", {16'd0, s_frame_count}, 32'd0);
    check("s_async_flags", {27'd0, s_pix_en, s_hSync, s_vSync, s_bright, s_frame_tick}, 32'd0);
    check("d_async_cnt", {12'd0, d_hCount, d_vCount}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(3);
    check("s_restart_pix_en", {31'd0, s_pix_en}, 32'd1);
    check("s_restart_pos", {12'd0, s_hCount, s_vCount}, 32'd0);
    step(1);
    check("s_restart_h1", {12'd0, s_hCount, s_vCount}, {12'd0, 10'd1, 10'd0});

    // ---- frame counter wrap from 65535 ----
    force dut_s.frame_count = 16'hffff;
    #1 release dut_s.frame_count;
    #1 check("s_fc_preload", {16'd0, s_frame_count}, 32'h0000ffff);
    step(795);
    check("s_fc_hold_ffff", {16'd0, s_frame_count}, 32'h0000ffff);
    check("s_tick_pre_rollover", {31'd0, s_frame_tick}, 32'd0);
    step(1);
    check("s_fc_rollover", {16'd0, s_frame_count}, 32'd0);
    check("s_tick_rollover", {31'd0, s_frame_tick}, 32'd1);
    step(1);
    check("s_tick_one_clk", {31'd0, s_frame_tick}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
